// File: rtl/mac_timestep_scheduler.sv
// mac_timestep_scheduler: buffers spike source addresses in a FIFO and replays
// them to the 5-synapse spike MAC one per cycle. It also generates the MAC's
// set (initialisation) window and the clear pulse that closes every timestep.
// Every output is registered; the combinational block computes next values.
module mac_timestep_scheduler #(
    parameter int                   ADDR_BITS       = 12,
    parameter int                   FIFO_DEPTH      = 8,
    parameter int                   TIMESTEP_CYCLES = 64,
    parameter int                   INIT_CYCLES     = 4,
    parameter logic [ADDR_BITS-1:0] IDLE_ADDR       = {ADDR_BITS{1'b1}}
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 spike_valid,
    input  logic [ADDR_BITS-1:0] spike_addr,
    output logic                 spike_ready,
    output logic                 mac_set,
    output logic [ADDR_BITS-1:0] mac_source_address,
    output logic                 mac_addr_valid,
    output logic                 mac_clear,
    output logic                 timestep_done,
    output logic [15:0]          timestep_count,
    output logic                 busy
);

    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int COUNT_BITS = PTR_BITS + 1;
    localparam int TIMER_BITS = $clog2(TIMESTEP_CYCLES);
    localparam int INIT_BITS  = $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, INIT, RUN, CLEAR} state_t;

    state_t                state, state_next;
    logic [TIMER_BITS-1:0] timer, timer_next;
    logic [INIT_BITS-1:0]  init_timer, init_timer_next;
    logic                  stop_pending, stop_pending_next;

    logic [ADDR_BITS-1:0]  mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr, wr_ptr_next;
    logic [PTR_BITS-1:0]   rd_ptr, rd_ptr_next;
    logic [COUNT_BITS-1:0] count, count_next;

    logic                  push, pop, flush;
    logic                  set_next, addr_valid_next, clear_next, done_next;
    logic [ADDR_BITS-1:0]  addr_next;
    logic [15:0]           ts_count_next;

    // A transfer happens on the registered ready; a start flushes the buffer,
    // so a push in that same cycle is discarded along with older entries.
    assign push = spike_valid && spike_ready && !flush;

    // FIFO storage holds no control state, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= spike_addr;
        end
    end

    // Next-state, scheduling and FIFO bookkeeping for the sequencer.
    always_comb begin
        state_next        = state;
        timer_next        = timer;
        init_timer_next   = init_timer;
        stop_pending_next = stop_pending;
        set_next          = 1'b0;
        addr_next         = IDLE_ADDR;
        addr_valid_next   = 1'b0;
        clear_next        = 1'b0;
        done_next         = 1'b0;
        ts_count_next     = timestep_count;
        pop               = 1'b0;
        flush             = 1'b0;

        case (state)
            IDLE: begin
                stop_pending_next = 1'b0;
                if (start) begin
                    state_next      = INIT;
                    set_next        = 1'b1;
                    init_timer_next = '0;
                    ts_count_next   = '0;
                    flush           = 1'b1;
                end
            end
            INIT: begin
                stop_pending_next = stop_pending || stop;
                set_next          = 1'b1;
                if (init_timer == INIT_BITS'(INIT_CYCLES - 1)) begin
                    state_next = RUN;
                    timer_next = '0;
                    set_next   = 1'b0;
                end else begin
                    init_timer_next = init_timer + 1'b1;
                end
            end
            RUN: begin
                stop_pending_next = stop_pending || stop;
                timer_next        = timer + 1'b1;
                if (count != '0) begin
                    pop             = 1'b1;
                    addr_next       = mem[rd_ptr];
                    addr_valid_next = 1'b1;
                end
                if (timer == TIMER_BITS'(TIMESTEP_CYCLES - 1)) begin
                    state_next = CLEAR;
                    timer_next = '0;
                end
            end
            CLEAR: begin
                clear_next        = 1'b1;
                done_next         = 1'b1;
                ts_count_next     = timestep_count + 16'd1;
                timer_next        = '0;
                stop_pending_next = 1'b0;
                if (stop_pending || stop) begin
                    state_next = IDLE;
                end else begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_next = count + 1'b1;
            end else if (pop && !push) begin
                count_next = count - 1'b1;
            end
        end
    end

    // State, timers, FIFO pointers and all registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state              <= IDLE;
            timer              <= '0;
            init_timer         <= '0;
            stop_pending       <= 1'b0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            spike_ready        <= 1'b1;
            mac_set            <= 1'b0;
            mac_source_address <= IDLE_ADDR;
            mac_addr_valid     <= 1'b0;
            mac_clear          <= 1'b0;
            timestep_done      <= 1'b0;
            timestep_count     <= '0;
            busy               <= 1'b0;
        end else begin
            state              <= state_next;
            timer              <= timer_next;
            init_timer         <= init_timer_next;
            stop_pending       <= stop_pending_next;
            wr_ptr             <= wr_ptr_next;
            rd_ptr             <= rd_ptr_next;
            count              <= count_next;
            spike_ready        <= (count_next != COUNT_BITS'(FIFO_DEPTH)) && (state_next != INIT);
            mac_set            <= set_next;
            mac_source_address <= addr_next;
            mac_addr_valid     <= addr_valid_next;
            mac_clear          <= clear_next;
            timestep_done      <= done_next;
            timestep_count     <= ts_count_next;
            busy               <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_mac_timestep_scheduler.sv
// Testbench for mac_timestep_scheduler with TIMESTEP_CYCLES=8, INIT_CYCLES=4,
// FIFO_DEPTH=8. A cycle-by-cycle vector table covers init, replay, clear
// cadence, stop and start handling; hand-written sequences cover async reset,
// FIFO full back-pressure and carry-over of events across a timestep boundary.
module tb_mac_timestep_scheduler;

    localparam logic [11:0] IDLE = 12'hFFF;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        spike_valid = 1'b0;
    logic [11:0] spike_addr = '0;
    logic        spike_ready;
    logic        mac_set;
    logic [11:0] mac_source_address;
    logic        mac_addr_valid;
    logic        mac_clear;
    logic        timestep_done;
    logic [15:0] timestep_count;
    logic        busy;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic        start;
        logic        stop;
        logic        valid;
        logic [11:0] addr;
        logic        e_set;
        logic [11:0] e_addr;
        logic        e_valid;
        logic        e_clear;
        logic [15:0] e_ts;
        logic        e_busy;
        logic        e_ready;
    } vec_t;

    vec_t vecs[$];

    mac_timestep_scheduler #(
        .ADDR_BITS(12),
        .FIFO_DEPTH(8),
        .TIMESTEP_CYCLES(8),
        .INIT_CYCLES(4),
        .IDLE_ADDR(12'hFFF)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .stop(stop),
        .spike_valid(spike_valid),
        .spike_addr(spike_addr),
        .spike_ready(spike_ready),
        .mac_set(mac_set),
        .mac_source_address(mac_source_address),
        .mac_addr_valid(mac_addr_valid),
        .mac_clear(mac_clear),
        .timestep_done(timestep_done),
        .timestep_count(timestep_count),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic s, input logic p, input logic v,
                       input logic [11:0] a, input logic e_set, input logic [11:0] e_addr,
                       input logic e_valid, input logic e_clear, input logic [15:0] e_ts,
                       input logic e_busy, input logic e_ready);
        vec_t r;
        r.start = s;       r.stop = p;        r.valid = v;     r.addr = a;
        r.e_set = e_set;   r.e_addr = e_addr; r.e_valid = e_valid;
        r.e_clear = e_clear; r.e_ts = e_ts;   r.e_busy = e_busy; r.e_ready = e_ready;
        for (int i = 0; i < n; i++) begin
            vecs.push_back(r);
        end
    endtask

    task automatic applyStimulus(input vec_t r);
        start       = r.start;
        stop        = r.stop;
        spike_valid = r.valid;
        spike_addr  = r.addr;
        tick();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".set"}, mac_set, 1'b0);
        checkOutput({tag, ".addr"}, mac_source_address, IDLE);
        checkOutput({tag, ".valid"}, mac_addr_valid, 1'b0);
        checkOutput({tag, ".clear"}, mac_clear, 1'b0);
        checkOutput({tag, ".done"}, timestep_done, 1'b0);
        checkOutput({tag, ".ts"}, timestep_count, 16'd0);
        checkOutput({tag, ".busy"}, busy, 1'b0);
        checkOutput({tag, ".ready"}, spike_ready, 1'b1);
    endtask

    initial begin
        int accepted;
        int recv;
        int clears;
        logic rdy;
        int idx;

        // Columns: n, start, stop, valid, addr | set, addr, valid, clear, ts, busy, ready
        add(1, 1, 0, 0, 12'd0, 1, IDLE,  0, 0, 16'd0, 1, 0);  // start: INIT
        add(3, 0, 0, 0, 12'd0, 1, IDLE,  0, 0, 16'd0, 1, 0);
        add(1, 0, 0, 0, 12'd0, 0, IDLE,  0, 0, 16'd0, 1, 1);  // RUN t0
        add(1, 0, 0, 1, 12'd3, 0, IDLE,  0, 0, 16'd0, 1, 1);
        add(1, 0, 0, 1, 12'd5, 0, 12'd3, 1, 0, 16'd0, 1, 1);
        add(1, 0, 0, 1, 12'd7, 0, 12'd5, 1, 0, 16'd0, 1, 1);
        add(1, 0, 0, 0, 12'd0, 0, 12'd7, 1, 0, 16'd0, 1, 1);
        add(1, 0, 0, 0, 12'd0, 0, IDLE,  0, 0, 16'd0, 1, 1);
        add(1, 1, 0, 0, 12'd0, 0, IDLE,  0, 0, 16'd0, 1, 1);  // start in RUN ignored
        add(2, 0, 0, 0, 12'd0, 0, IDLE,  0, 0, 16'd0, 1, 1);
        add(1, 0, 0, 0, 12'd0, 0, IDLE,  0, 1, 16'd1, 1, 1);  // first clear
        add(8, 0, 0, 0, 12'd0, 0, IDLE,  0, 0, 16'd1, 1, 1);
        add(1, 0, 0, 0, 12'd0, 0, IDLE,  0, 1, 16'd2, 1, 1);  // second clear, 9 later
        add(2, 0, 0, 0, 12'd0, 0, IDLE,  0, 0, 16'd2, 1, 1);
        add(1, 0, 1, 0, 12'd0, 0, IDLE,  0, 0, 16'd2, 1, 1);  // stop at timer 2
        add(5, 0, 0, 0, 12'd0, 0, IDLE,  0, 0, 16'd2, 1, 1);
        add(1, 0, 0, 0, 12'd0, 0, IDLE,  0, 1, 16'd3, 0, 1);  // final clear, to IDLE
        add(1, 0, 0, 0, 12'd0, 0, IDLE,  0, 0, 16'd3, 0, 1);
        add(1, 0, 0, 1, 12'd9, 0, IDLE,  0, 0, 16'd3, 0, 1);  // push in IDLE, no pop
        add(1, 0, 0, 0, 12'd0, 0, IDLE,  0, 0, 16'd3, 0, 1);
        add(1, 1, 1, 0, 12'd0, 1, IDLE,  0, 0, 16'd0, 1, 0);  // start+stop: start wins
        add(3, 0, 0, 0, 12'd0, 1, IDLE,  0, 0, 16'd0, 1, 0);
        add(1, 0, 0, 0, 12'd0, 0, IDLE,  0, 0, 16'd0, 1, 1);
        add(8, 0, 0, 0, 12'd0, 0, IDLE,  0, 0, 16'd0, 1, 1);  // flushed event 9 absent
        add(1, 0, 0, 0, 12'd0, 0, IDLE,  0, 1, 16'd1, 1, 1);  // stays busy

        repeat (2) @(posedge CLK);
        #1;
        checkResetValues("reset");
        RST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d.set", i), mac_set, vecs[i].e_set);
            checkOutput($sformatf("row%0d.addr", i), mac_source_address, vecs[i].e_addr);
            checkOutput($sformatf("row%0d.valid", i), mac_addr_valid, vecs[i].e_valid);
            checkOutput($sformatf("row%0d.clear", i), mac_clear, vecs[i].e_clear);
            checkOutput($sformatf("row%0d.done", i), timestep_done, vecs[i].e_clear);
            checkOutput($sformatf("row%0d.ts", i), timestep_count, vecs[i].e_ts);
            checkOutput($sformatf("row%0d.busy", i), busy, vecs[i].e_busy);
            checkOutput($sformatf("row%0d.ready", i), spike_ready, vecs[i].e_ready);
        end
        start = 1'b0;
        stop  = 1'b0;

        // Async reset in the middle of RUN right after a burst of pushes.
        for (int k = 0; k < 3; k++) begin
            spike_valid = 1'b1;
            spike_addr  = 12'h020 + 12'(k);
            tick();
        end
        spike_valid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        checkResetValues("async_rst");
        tick();
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("post_rst%0d.valid", k), mac_addr_valid, 1'b0);
            checkOutput($sformatf("post_rst%0d.busy", k), busy, 1'b0);
            checkOutput($sformatf("post_rst%0d.set", k), mac_set, 1'b0);
        end

        // Fill the empty FIFO in IDLE with valid held: exactly 8 accepted.
        accepted = 0;
        for (int k = 0; k < 12; k++) begin
            spike_valid = 1'b1;
            spike_addr  = 12'h040 + 12'(k);
            rdy = spike_ready;
            tick();
            if (rdy) accepted++;
            checkOutput($sformatf("fill%0d.ready", k), spike_ready, (k < 7) ? 1'b1 : 1'b0);
        end
        spike_valid = 1'b0;
        checkOutput("fill.accepted", accepted, 8);

        // Start flushes the full FIFO, then 12 events stream across two boundaries.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("c.set", mac_set, 1'b1);
        for (int i = 0; i < 10 && mac_set; i++) begin
            tick();
        end
        checkOutput("c.init_end", mac_set, 1'b0);
        repeat (4) tick();

        idx = 0;
        recv = 0;
        clears = 0;
        for (int cyc = 0; cyc < 80 && recv < 12; cyc++) begin
            spike_valid = (idx < 12);
            spike_addr  = 12'h100 + 12'(idx);
            rdy = spike_ready;
            tick();
            if (spike_valid && rdy) idx++;
            if (mac_clear) begin
                clears++;
                checkOutput($sformatf("c.clear%0d.valid", clears), mac_addr_valid, 1'b0);
                checkOutput($sformatf("c.clear%0d.ts", clears), timestep_count, 16'(clears));
                checkOutput($sformatf("c.clear%0d.recv", clears), recv, (clears == 1) ? 3 : 11);
            end
            if (mac_addr_valid) begin
                checkOutput($sformatf("c.ev%0d", recv), mac_source_address, 12'h100 + 12'(recv));
                recv++;
            end
        end
        spike_valid = 1'b0;
        checkOutput("c.received", recv, 12);
        checkOutput("c.clears", clears, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
